// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared definitions for the router output-channel packet FIFO.
//   wr_state_e      : write-side FSM states
//   SOP_BIT/EOP_BIT : flag positions inside the 2-bit field stored above data
//   HDR_*           : header byte fields (length [7:2], destination [1:0])
//   hdr_len/hdr_addr: header field extraction helpers
// ---------------------------------------------------------------------------
package router_pkg;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_PKT     = 2'd1,
        WR_DISCARD = 2'd2
    } wr_state_e;

    // A stored entry is {sop, eop, data}; these index the flag pair that sits
    // immediately above the data bits.
    localparam int EOP_BIT = 0;
    localparam int SOP_BIT = 1;
    localparam int FLAG_W  = 2;

    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    function automatic logic [HDR_LEN_MSB-HDR_LEN_LSB:0] hdr_len(input logic [7:0] hdr);
        return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

    function automatic logic [HDR_ADDR_MSB-HDR_ADDR_LSB:0] hdr_addr(input logic [7:0] hdr);
        return hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// ---------------------------------------------------------------------------
// router_fifo_mem
// Simple dual-port storage, DEPTH x WIDTH, one write and one read port on the
// same clock. The read data register only loads when re is high, so it holds
// its last value otherwise; srst clears that register (not the array).
//   clk, srst          : clock, synchronous active-high reset of read register
//   we, waddr, wdata   : write port
//   re, raddr, rdata   : read port, rdata valid the cycle after re
// ---------------------------------------------------------------------------
module router_fifo_mem #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/router_pkt_fifo.sv
// ---------------------------------------------------------------------------
// router_pkt_fifo
// Store-and-forward packet FIFO between the router register block (writer)
// and one output port (reader). Bytes become readable only once the packet's
// last byte has been written (committed); partial packets can be aborted,
// restarted by a new header, or discarded on overflow.
//   clock, reset, soft_reset : clock, synchronous active-high resets (same effect)
//   write_enb, lfd_state, wr_last, wr_abort, data_in : write side
//   read_enb, data_out, data_valid, rd_sop, rd_eop   : read side (1-cycle latency)
//   full, almost_full, empty, fill_level, pkt_count  : status
//   drop_err : one-cycle pulse when a write is dropped
// ---------------------------------------------------------------------------
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 14
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    soft_reset,
    input  logic                    write_enb,
    input  logic                    lfd_state,
    input  logic                    wr_last,
    input  logic                    wr_abort,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    read_enb,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid,
    output logic                    rd_sop,
    output logic                    rd_eop,
    output logic                    full,
    output logic                    almost_full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic [$clog2(DEPTH):0]  pkt_count,
    output logic                    drop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DATA_WIDTH + FLAG_W;

    logic          srst;
    wr_state_e     state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] pkt_count_q, pkt_count_d;
    logic          drop_err_q, drop_err_d;
    logic          data_valid_q, data_valid_d;

    logic          take_hdr, take_data, overflow, commit_now;
    logic [PW-1:0] wr_base;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [EW-1:0] mem_wdata, mem_rdata;
    logic          rd_fire, rd_eop_now;

    // Copy of each entry's eop flag, readable in the same cycle as the read
    // request so pkt_count can drop on the same edge that advances rd_ptr.
    logic [DEPTH-1:0] eop_shadow_q;

    assign srst        = reset | soft_reset;
    assign full        = (wr_ptr_q == {~rd_ptr_q[PW-1], rd_ptr_q[PW-2:0]});
    assign empty       = (rd_ptr_q == commit_ptr_q);
    assign fill_level  = wr_ptr_q - rd_ptr_q;
    assign almost_full = (fill_level >= PW'(AFULL_THRESH));
    assign pkt_count   = pkt_count_q;
    assign drop_err    = drop_err_q;
    assign data_valid  = data_valid_q;
    assign data_out    = mem_rdata[DATA_WIDTH-1:0];
    assign rd_sop      = mem_rdata[DATA_WIDTH+SOP_BIT];
    assign rd_eop      = mem_rdata[DATA_WIDTH+EOP_BIT];

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_err_d   = 1'b0;
        take_hdr     = 1'b0;
        take_data    = 1'b0;
        overflow     = 1'b0;

        if (wr_abort) begin
            wr_ptr_d = commit_ptr_q;
            state_d  = WR_IDLE;
        end else if (write_enb) begin
            case (state_q)
                WR_IDLE: begin
                    if (full)           overflow   = 1'b1;
                    else if (lfd_state) take_hdr   = 1'b1;
                    else                drop_err_d = 1'b1;
                end
                WR_PKT: begin
                    if (full)           overflow  = 1'b1;
                    else if (lfd_state) take_hdr  = 1'b1;
                    else                take_data = 1'b1;
                end
                WR_DISCARD: begin
                    if (lfd_state && !full) take_hdr = 1'b1;
                end
                default: state_d = WR_IDLE;
            endcase
        end

        if (overflow) begin
            drop_err_d = 1'b1;
            wr_ptr_d   = commit_ptr_q;
            state_d    = WR_DISCARD;
        end

        // A header always lands at the commit point: in WR_IDLE/WR_DISCARD
        // wr_ptr already equals commit_ptr, and in WR_PKT it drops the
        // unterminated packet being built.
        wr_base    = take_hdr ? commit_ptr_q : wr_ptr_q;
        mem_we     = take_hdr | take_data;
        mem_waddr  = wr_base[AW-1:0];
        mem_wdata  = {take_hdr, wr_last, data_in};
        commit_now = mem_we & wr_last;

        if (mem_we) begin
            wr_ptr_d = wr_base + PW'(1);
            if (wr_last) begin
                commit_ptr_d = wr_base + PW'(1);
                state_d      = WR_IDLE;
            end else begin
                state_d      = WR_PKT;
            end
        end

        rd_fire      = read_enb & ~empty;
        rd_ptr_d     = rd_ptr_q + (rd_fire ? PW'(1) : PW'(0));
        rd_eop_now   = rd_fire & eop_shadow_q[rd_ptr_q[AW-1:0]];
        data_valid_d = rd_fire;

        pkt_count_d = pkt_count_q;
        if (commit_now && !rd_eop_now) begin
            pkt_count_d = pkt_count_q + PW'(1);
        end else if (!commit_now && rd_eop_now) begin
            pkt_count_d = pkt_count_q - PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (srst) begin
            state_q      <= WR_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            pkt_count_q  <= '0;
            drop_err_q   <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_count_q  <= pkt_count_d;
            drop_err_q   <= drop_err_d;
            data_valid_q <= data_valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we && !srst) begin
            eop_shadow_q[mem_waddr] <= wr_last;
        end
    end

    router_fifo_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clock),
        .srst  (srst),
        .we    (mem_we & ~srst),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (rd_fire & ~srst),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

endmodule
